// File: rtl/blast_stun_ctrl.sv
// blast_stun_ctrl
//
// Applies square (Chebyshev) blast areas from every player's bomb to every
// player. A player caught in a blast is stunned for STUN_CYCLES clocks. It is
// then immune for IMMUNE_CYCLES clocks, and after that it can be hit again.
// Each player runs its own IDLE/STUN/IMMUNE state machine. No state is
// shared between players.
//
// Ports
//   clk           system clock
//   resetn        asynchronous active-low reset
//   bomb_explode  one-cycle explosion pulse per bomb (bomb i owned by player i)
//   bomb_x/y      packed bomb coordinates, bomb i at [i*COORD_W +: COORD_W]
//   player_x/y    packed player coordinates, same packing
//   stunned       high while the player is in STUN (movement must freeze)
//   immune        high while the player is in IMMUNE
//   stun_pulse    one-cycle pulse on entry to STUN (renderer colour / SFX)
//   hit_by        hit_by[p*NUM_PLAYERS+b] pulses with stun_pulse[p] when
//                 bomb b contributed to that stun
module blast_stun_ctrl #(
    parameter int NUM_PLAYERS   = 2,
    parameter int COORD_W       = 6,
    parameter int RADIUS        = 1,
    parameter int STUN_CYCLES   = 250000000,
    parameter int IMMUNE_CYCLES = 50000000,
    parameter int FRIENDLY_FIRE = 1,
    parameter int CNT_W         = 28
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic [NUM_PLAYERS-1:0]           bomb_explode,
    input  logic [NUM_PLAYERS*COORD_W-1:0]   bomb_x,
    input  logic [NUM_PLAYERS*COORD_W-1:0]   bomb_y,
    input  logic [NUM_PLAYERS*COORD_W-1:0]   player_x,
    input  logic [NUM_PLAYERS*COORD_W-1:0]   player_y,
    output logic [NUM_PLAYERS-1:0]           stunned,
    output logic [NUM_PLAYERS-1:0]           immune,
    output logic [NUM_PLAYERS-1:0]           stun_pulse,
    output logic [NUM_PLAYERS*NUM_PLAYERS-1:0] hit_by
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STUN   = 2'd1,
        ST_IMMUNE = 2'd2
    } state_t;

    // One extra bit for the difference, so that coordinates never wrap
    // around the board edge.
    localparam int                DW          = COORD_W + 1;
    localparam logic [DW-1:0]     RAD         = DW'(RADIUS);
    localparam bit                HAS_IMMUNE  = (IMMUNE_CYCLES > 0);
    localparam logic [CNT_W-1:0]  STUN_LOAD   = CNT_W'(STUN_CYCLES - 1);
    localparam logic [CNT_W-1:0]  IMMUNE_LOAD = HAS_IMMUNE ? CNT_W'(IMMUNE_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);

    // |a - b| computed in signed COORD_W+1 arithmetic.
    function automatic logic [DW-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                               input logic [COORD_W-1:0] b);
        logic signed [DW-1:0] d;
        d = signed'({1'b0, a}) - signed'({1'b0, b});
        return (d < 0) ? unsigned'(-d) : unsigned'(d);
    endfunction

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        logic [NUM_PLAYERS-1:0] hit;
        state_t                 state_q, state_d;
        logic [CNT_W-1:0]       cnt_q, cnt_d;
        logic                   pulse_q, pulse_d;
        logic [NUM_PLAYERS-1:0] hit_by_q, hit_by_d;

        for (genvar b = 0; b < NUM_PLAYERS; b++) begin : g_bomb
            // With friendly fire off, a bomb never affects its own owner.
            localparam bit ALLOWED = (FRIENDLY_FIRE != 0) || (p != b);

            assign hit[b] = ALLOWED && bomb_explode[b]
                && (abs_diff(player_x[p*COORD_W +: COORD_W], bomb_x[b*COORD_W +: COORD_W]) <= RAD)
                && (abs_diff(player_y[p*COORD_W +: COORD_W], bomb_y[b*COORD_W +: COORD_W]) <= RAD);
        end

        // NOTE: every signal in this block gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        always_comb begin
            state_d  = state_q;
            cnt_d    = cnt_q;
            pulse_d  = 1'b0;
            hit_by_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (|hit) begin
                        state_d  = ST_STUN;
                        cnt_d    = STUN_LOAD;
                        pulse_d  = 1'b1;
                        hit_by_d = hit;
                    end
                end
                // Hits are ignored in STUN and IMMUNE. This includes the
                // final edge that returns to IDLE.
                ST_STUN: begin
                    if (cnt_q == '0) begin
                        if (HAS_IMMUNE) begin
                            state_d = ST_IMMUNE;
                            cnt_d   = IMMUNE_LOAD;
                        end else begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                ST_IMMUNE: begin
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // NOTE: state registers use non-blocking assignments, so every
        // register samples the values from before the edge.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                state_q  <= ST_IDLE;
                cnt_q    <= '0;
                pulse_q  <= 1'b0;
                hit_by_q <= '0;
            end else begin
                state_q  <= state_d;
                cnt_q    <= cnt_d;
                pulse_q  <= pulse_d;
                hit_by_q <= hit_by_d;
            end
        end

        assign stunned[p]                               = (state_q == ST_STUN);
        assign immune[p]                                = (state_q == ST_IMMUNE);
        assign stun_pulse[p]                            = pulse_q;
        assign hit_by[p*NUM_PLAYERS +: NUM_PLAYERS]     = hit_by_q;
    end

endmodule

// File: tb/tb_blast_stun_ctrl.sv
// Self-checking bench for blast_stun_ctrl.
// Four instances share the same stimulus:
//   m   : RADIUS=1, FRIENDLY_FIRE=1, STUN=5, IMMUNE=3
//   r2  : RADIUS=2
//   nf  : FRIENDLY_FIRE=0
//   z   : IMMUNE_CYCLES=0
module tb_blast_stun_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic [1:0]  explode;
    logic [11:0] bx, by, px, py;

    logic [1:0] st_m, im_m, sp_m;   logic [3:0] hb_m;
    logic [1:0] st_r2, im_r2, sp_r2; logic [3:0] hb_r2;
    logic [1:0] st_nf, im_nf, sp_nf; logic [3:0] hb_nf;
    logic [1:0] st_z, im_z, sp_z;   logic [3:0] hb_z;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    blast_stun_ctrl #(.NUM_PLAYERS(2), .COORD_W(6), .RADIUS(1), .STUN_CYCLES(5),
                      .IMMUNE_CYCLES(3), .FRIENDLY_FIRE(1), .CNT_W(28)) u_m (
        .clk(clk), .resetn(resetn), .bomb_explode(explode),
        .bomb_x(bx), .bomb_y(by), .player_x(px), .player_y(py),
        .stunned(st_m), .immune(im_m), .stun_pulse(sp_m), .hit_by(hb_m));

    blast_stun_ctrl #(.NUM_PLAYERS(2), .COORD_W(6), .RADIUS(2), .STUN_CYCLES(5),
                      .IMMUNE_CYCLES(3), .FRIENDLY_FIRE(1), .CNT_W(28)) u_r2 (
        .clk(clk), .resetn(resetn), .bomb_explode(explode),
        .bomb_x(bx), .bomb_y(by), .player_x(px), .player_y(py),
        .stunned(st_r2), .immune(im_r2), .stun_pulse(sp_r2), .hit_by(hb_r2));

    blast_stun_ctrl #(.NUM_PLAYERS(2), .COORD_W(6), .RADIUS(1), .STUN_CYCLES(5),
                      .IMMUNE_CYCLES(3), .FRIENDLY_FIRE(0), .CNT_W(28)) u_nf (
        .clk(clk), .resetn(resetn), .bomb_explode(explode),
        .bomb_x(bx), .bomb_y(by), .player_x(px), .player_y(py),
        .stunned(st_nf), .immune(im_nf), .stun_pulse(sp_nf), .hit_by(hb_nf));

    blast_stun_ctrl #(.NUM_PLAYERS(2), .COORD_W(6), .RADIUS(1), .STUN_CYCLES(5),
                      .IMMUNE_CYCLES(0), .FRIENDLY_FIRE(1), .CNT_W(28)) u_z (
        .clk(clk), .resetn(resetn), .bomb_explode(explode),
        .bomb_x(bx), .bomb_y(by), .player_x(px), .player_y(py),
        .stunned(st_z), .immune(im_z), .stun_pulse(sp_z), .hit_by(hb_z));

    typedef struct {
        logic [1:0] ex;
        logic [5:0] bx0, by0, bx1, by1, px0, py0, px1, py1;
        logic [1:0] sp_m;
        logic [3:0] hb_m;
        logic [1:0] sp_r2;
        logic [1:0] sp_nf;
        logic [3:0] hb_nf;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_pos(input logic [5:0] bx0, input logic [5:0] by0,
                             input logic [5:0] bx1, input logic [5:0] by1,
                             input logic [5:0] px0, input logic [5:0] py0,
                             input logic [5:0] px1, input logic [5:0] py1);
        bx = {bx1, bx0};
        by = {by1, by0};
        px = {px1, px0};
        py = {py1, py0};
    endtask

    // Reset at a falling edge. Release one cycle later, so the next rising
    // edge is the first one after reset is released.
    task automatic reset_cycle();
        @(negedge clk);
        resetn  = 1'b0;
        explode = 2'b00;
        @(negedge clk);
        resetn  = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected end before 200000");
        $fatal(1);
    end

    initial begin
        logic [1:0] sched [17];
        logic [1:0] e_st_m, e_im_m, e_sp_m, e_st_z, e_sp_z;
        logic [3:0] e_hb_m;

        //             ex     b0       b1       p0       p1       sp_m   hb_m     sp_r2  sp_nf  hb_nf
        vecs[0]  = '{2'b01, 10, 10, 50, 50, 20, 20, 11,  9, 2'b10, 4'b0100, 2'b10, 2'b10, 4'b0100}; // corner
        vecs[1]  = '{2'b01, 10, 10, 50, 50, 20, 20, 12, 10, 2'b00, 4'b0000, 2'b10, 2'b00, 4'b0000}; // x edge
        vecs[2]  = '{2'b01,  0,  0, 50, 50, 30, 30, 63,  0, 2'b00, 4'b0000, 2'b00, 2'b00, 4'b0000}; // no x wrap
        vecs[3]  = '{2'b01,  5,  5, 50, 50,  5,  5, 30, 30, 2'b01, 4'b0001, 2'b01, 2'b00, 4'b0000}; // own bomb
        vecs[4]  = '{2'b11, 20, 20, 21, 21, 40, 40, 20, 21, 2'b10, 4'b1100, 2'b10, 2'b10, 4'b0100}; // two bombs
        vecs[5]  = '{2'b10, 50, 50, 30, 30, 31, 31, 29, 30, 2'b11, 4'b1010, 2'b11, 2'b01, 4'b0010}; // one bomb, two players
        vecs[6]  = '{2'b01, 10, 10, 50, 50, 20, 20, 10, 12, 2'b00, 4'b0000, 2'b10, 2'b00, 4'b0000}; // y edge
        vecs[7]  = '{2'b00,  5,  5,  5,  5,  5,  5,  5,  5, 2'b00, 4'b0000, 2'b00, 2'b00, 4'b0000}; // no explosion
        vecs[8]  = '{2'b10,  0,  0, 63, 63, 62, 62,  0, 63, 2'b01, 4'b0010, 2'b01, 2'b01, 4'b0010}; // top corner
        vecs[9]  = '{2'b01,  7,  0, 50, 50,  7, 63, 40, 40, 2'b00, 4'b0000, 2'b00, 2'b00, 4'b0000}; // no y wrap
        vecs[10] = '{2'b01, 10, 10, 50, 50, 20, 20, 12,  8, 2'b00, 4'b0000, 2'b10, 2'b00, 4'b0000}; // diagonal r2

        resetn  = 1'b0;
        explode = 2'b00;
        drive_pos(0, 0, 0, 0, 30, 30, 40, 40);
        #3;
        check("reset_stunned", {st_m, st_r2, st_nf, st_z}, 32'h0);
        check("reset_immune", {im_m, im_r2, im_nf, im_z}, 32'h0);
        check("reset_pulse", {sp_m, sp_r2, sp_nf, sp_z}, 32'h0);
        check("reset_hit_by", {hb_m, hb_r2, hb_nf, hb_z}, 32'h0);

        // Single-explosion vectors, each starting from reset.
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            resetn  = 1'b0;
            explode = 2'b00;
            drive_pos(vecs[i].bx0, vecs[i].by0, vecs[i].bx1, vecs[i].by1,
                      vecs[i].px0, vecs[i].py0, vecs[i].px1, vecs[i].py1);
            @(negedge clk);
            resetn  = 1'b1;
            explode = vecs[i].ex;
            @(negedge clk);
            explode = 2'b00;
            check($sformatf("v%0d_pulse_m", i), sp_m, vecs[i].sp_m);
            check($sformatf("v%0d_hit_by_m", i), hb_m, vecs[i].hb_m);
            check($sformatf("v%0d_stunned_m", i), st_m, vecs[i].sp_m);
            check($sformatf("v%0d_pulse_r2", i), sp_r2, vecs[i].sp_r2);
            check($sformatf("v%0d_pulse_nf", i), sp_nf, vecs[i].sp_nf);
            check($sformatf("v%0d_hit_by_nf", i), hb_nf, vecs[i].hb_nf);
            check($sformatf("v%0d_pulse_z", i), sp_z, vecs[i].sp_m);
        end

        // Durations and ignored hits. Bomb 0 at (10,10) hits player 1 at
        // (11,9); player 0 at (20,20) is out of range. Explosions at edges
        // 0,2,5,6,8,9. For m: stun 0-4, immune 5-7, edge 8 ignored, re-stun
        // at 9. For z: stun 0-4, edge 5 ignored, re-stun at 6 (6-10).
        for (int k = 0; k < 17; k++) sched[k] = 2'b00;
        sched[0] = 2'b01; sched[2] = 2'b01; sched[5] = 2'b01;
        sched[6] = 2'b01; sched[8] = 2'b01; sched[9] = 2'b01;
        drive_pos(10, 10, 50, 50, 20, 20, 11, 9);
        @(negedge clk);
        resetn  = 1'b0;
        @(negedge clk);
        resetn  = 1'b1;
        explode = sched[0];
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            e_st_m = ((k <= 4) || (k >= 9 && k <= 13)) ? 2'b10 : 2'b00;
            e_im_m = ((k >= 5 && k <= 7) || (k >= 14)) ? 2'b10 : 2'b00;
            e_sp_m = ((k == 0) || (k == 9)) ? 2'b10 : 2'b00;
            e_hb_m = ((k == 0) || (k == 9)) ? 4'b0100 : 4'b0000;
            e_st_z = ((k <= 4) || (k >= 6 && k <= 10)) ? 2'b10 : 2'b00;
            e_sp_z = ((k == 0) || (k == 6)) ? 2'b10 : 2'b00;
            check($sformatf("seq_k%0d_stunned_m", k), st_m, e_st_m);
            check($sformatf("seq_k%0d_immune_m", k), im_m, e_im_m);
            check($sformatf("seq_k%0d_pulse_m", k), sp_m, e_sp_m);
            check($sformatf("seq_k%0d_hit_by_m", k), hb_m, e_hb_m);
            check($sformatf("seq_k%0d_stunned_z", k), st_z, e_st_z);
            check($sformatf("seq_k%0d_immune_z", k), im_z, 2'b00);
            check($sformatf("seq_k%0d_pulse_z", k), sp_z, e_sp_z);
            explode = sched[k+1];
        end

        // Reset in the second cycle of a stun clears the outputs without a clock edge.
        reset_cycle();
        explode = 2'b01;
        @(negedge clk);
        explode = 2'b00;
        check("rst_pre_pulse_m", sp_m, 2'b10);
        @(negedge clk);
        check("rst_pre_stunned_m", st_m, 2'b10);
        #1 resetn = 1'b0;
        #1;
        check("rst_async_stunned_m", st_m, 2'b00);
        check("rst_async_immune_m", im_m, 2'b00);
        check("rst_async_stunned_z", st_z, 2'b00);
        check("rst_async_hit_by_m", hb_m, 4'b0000);
        @(negedge clk);
        resetn = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("rst_post_k%0d_stunned", k), {st_m, st_z}, 4'b0000);
            check($sformatf("rst_post_k%0d_immune", k), {im_m, im_z}, 4'b0000);
            check($sformatf("rst_post_k%0d_pulse", k), {sp_m, sp_z}, 4'b0000);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
